dp_ctrl: RTL
============

Name: dp_ctrl

Overview:
- Microsequencer that drives the control inputs of the 3-bit datapath DP (mux1 select, register-file write/read ports, ALU function, output mux).
- On a single `go` pulse it performs one full operation: load in1 into RA, load in2 into RB, execute `op` on RA/RB with the result presented at DP out, then optionally write the result back to RD.
- Sits directly upstream of DP; its outputs connect 1:1 to DP's s1/we/wa/rea/raa/reb/rab/c/s2.

Parameters:
- AW, 2, register-file address width (raa/rab/wa/ra/rb/rd).
- CW, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start request, sampled only in IDLE
- op  in  2  ALU function for DP c: 11 = +, 10 = −, 01 = &, 00 = ^
- ra  in  AW  register address loaded from in1 (operand A)
- rb  in  AW  register address loaded from in2 (operand B)
- rd  in  AW  writeback destination address
- wb_en  in  1  1 = perform writeback of the ALU result to rd
- s1  out  2  DP mux1 select: 11 = in1, 10 = in2, 00 = ALU result; 01 is never driven
- we  out  1  DP write enable
- wa  out  AW  DP write address
- rea  out  1  DP read enable A
- raa  out  AW  DP read address A
- reb  out  1  DP read enable B
- rab  out  AW  DP read address B
- c  out  2  DP ALU select
- s2  out  1  DP output mux (1 = drive out)
- busy  out  1  high from the cycle after go is accepted until DONE exits
- done  out  1  one-cycle pulse in DONE
- op_cnt  out  CW  count of completed operations

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All outputs are 0: s1=00, we=0, wa=0, rea=reb=0, raa=rab=0, c=00, s2=0, busy=0, done=0, op_cnt=0.
  - Latched fields are cleared.
  - Asserting rst mid-operation aborts the operation immediately. The count is not incremented.
- All outputs are registered. Each value listed for a state is present during the cycles the FSM occupies that state, i.e. it updates on the edge that enters the state.
- IDLE:
  - All outputs are 0 except op_cnt.
  - When go=1 at a rising edge, latch op, ra, rb, rd and wb_en, then go to LD1. Inputs are not re-sampled until the FSM returns to IDLE.
  - go while busy is ignored (no queueing).
- LD1: s1=11, we=1, wa=ra_q. Next state is LD2, or EXE if ra_q==rb_q (both operands then read in1's value; LD2 is skipped).
- LD2: s1=10, we=1, wa=rb_q. Next state is EXE.
- EXE: we=0, rea=1, raa=ra_q, reb=1, rab=rb_q, c=op_q, s2=1. Next state is WB if wb_en_q=1, else DONE.
- WB: s1=00, we=1, wa=rd_q. rea, reb, raa, rab and c are held as in EXE so the ALU result is stable on the write path. s2=0. Next state is DONE.
- DONE: done=1, all other control outputs 0. op_cnt increments by 1 at the edge leaving DONE, wrapping 2^CW−1 → 0. Next state is IDLE.
- busy = 1 in LD1, LD2, EXE, WB and DONE.
- Latency from the go-accept edge to done high:
  - 5 cycles for the full path (LD1, LD2, EXE, WB, DONE).
  - −1 cycle if ra==rb.
  - −1 cycle if wb_en=0.
- rd may equal ra or rb; the writeback overwrites that register with no special handling.
- s1=01 and we=1 together with s1=00 outside WB are illegal and must never occur (assertion in bench).

Test Plan:
- Reset/idle: assert rst for 2 cycles, then release; hold go=0 for 10 cycles → every output stays 0, busy=0, op_cnt=0.
- XOR, no writeback: go with op=00, ra=01, rb=10, wb_en=0, DP in1=110, in2=010 → LD1 (s1=11, we=1, wa=01), LD2 (s1=10, wa=10), EXE (c=00, s2=1, DP out=100), done at cycle 4, op_cnt=1.
- AND with writeback: op=01, ra=01, rb=10, rd=11, wb_en=1 → WB cycle shows s1=00, we=1, wa=11. A follow-up op reading reg 11 via ra=rb=11 path check: DP reg 11 = 010. done at cycle 5.
- ra==rb: op=11, ra=rb=10, wb_en=0 → LD2 skipped; EXE raa=rab=10, c=11, DP out = in1+in1 = 110+110 = 100; done at cycle 3.
- go while busy: pulse go again during EXE with different op/ra → ignored; current operation completes with original values, op_cnt +1 only. Also set op_cnt to 255 via repeated ops → wraps to 0.
- Reset mid-op: assert rst during LD2 → outputs go to 0 asynchronously (before the next edge); after release FSM is in IDLE, op_cnt=0, no done pulse.

Source files
------------

// File: rtl/dp_ctrl.sv
// Microsequencer for the 3-bit datapath DP: on a go pulse loads in1/in2 into
// RA/RB, executes op, optionally writes the ALU result back to RD.
module dp_ctrl #(
    parameter int AW = 2,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [1:0]    op,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] rd,
    input  logic          wb_en,
    output logic [1:0]    s1,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic          rea,
    output logic [AW-1:0] raa,
    output logic          reb,
    output logic [AW-1:0] rab,
    output logic [1:0]    c,
    output logic          s2,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] op_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LD1,
        LD2,
        EXE,
        WB,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]    op_q;
    logic [AW-1:0] ra_q, rb_q, rd_q;
    logic          wb_en_q;

    logic [1:0]    s1_nx;
    logic          we_nx;
    logic [AW-1:0] wa_nx;
    logic          rea_nx;
    logic [AW-1:0] raa_nx;
    logic          reb_nx;
    logic [AW-1:0] rab_nx;
    logic [1:0]    c_nx;
    logic          s2_nx;
    logic          busy_nx;
    logic          done_nx;

    // Outputs are decoded from the state being entered so they are registered
    // and valid for exactly the cycles the FSM spends in that state.
    always_comb begin
        state_nx = state;
        s1_nx    = '0;
        we_nx    = 1'b0;
        wa_nx    = '0;
        rea_nx   = 1'b0;
        raa_nx   = '0;
        reb_nx   = 1'b0;
        rab_nx   = '0;
        c_nx     = '0;
        s2_nx    = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            IDLE:    if (go) state_nx = LD1;
            LD1:     state_nx = (ra_q == rb_q) ? EXE : LD2;
            LD2:     state_nx = EXE;
            EXE:     state_nx = wb_en_q ? WB : DONE;
            WB:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // LD1 is only entered from IDLE, where the fields are latched on the
        // same edge, so its write address comes straight from the input.
        case (state_nx)
            LD1: begin
                s1_nx   = 2'b11;
                we_nx   = 1'b1;
                wa_nx   = ra;
                busy_nx = 1'b1;
            end
            LD2: begin
                s1_nx   = 2'b10;
                we_nx   = 1'b1;
                wa_nx   = rb_q;
                busy_nx = 1'b1;
            end
            EXE: begin
                rea_nx  = 1'b1;
                raa_nx  = ra_q;
                reb_nx  = 1'b1;
                rab_nx  = rb_q;
                c_nx    = op_q;
                s2_nx   = 1'b1;
                busy_nx = 1'b1;
            end
            WB: begin
                s1_nx   = 2'b00;
                we_nx   = 1'b1;
                wa_nx   = rd_q;
                rea_nx  = 1'b1;
                raa_nx  = ra_q;
                reb_nx  = 1'b1;
                rab_nx  = rb_q;
                c_nx    = op_q;
                busy_nx = 1'b1;
            end
            DONE: begin
                done_nx = 1'b1;
                busy_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            s1      <= '0;
            we      <= 1'b0;
            wa      <= '0;
            rea     <= 1'b0;
            raa     <= '0;
            reb     <= 1'b0;
            rab     <= '0;
            c       <= '0;
            s2      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            op_cnt  <= '0;
        end else begin
            state <= state_nx;
            s1    <= s1_nx;
            we    <= we_nx;
            wa    <= wa_nx;
            rea   <= rea_nx;
            raa   <= raa_nx;
            reb   <= reb_nx;
            rab   <= rab_nx;
            c     <= c_nx;
            s2    <= s2_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            if (state == IDLE && go) begin
                op_q    <= op;
                ra_q    <= ra;
                rb_q    <= rb;
                rd_q    <= rd;
                wb_en_q <= wb_en;
            end
            if (state == DONE) op_cnt <= op_cnt + CW'(1);
        end
    end

endmodule
